qbert_move_ctrl: RTL and testbench

Q*bert jump sequencer: it drives the `qbert_jump` / `done_move` / colour-map side of the cube renderer.
- Accepts a jump command and tracks Q*bert's (row, column) on a 7-row pyramid.
- Animates the on-screen offset one step per video frame and pulses `done_move` on landing.
- Maintains the per-cube visited bitmap that feeds `nios_top_color`.

It sits between the NIOS/controller command path and the cube/sprite generators.

---
 rtl/qbert_move_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_qbert_move_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qbert_move_ctrl.sv
// Q*bert jump sequencer: tracks the (row, col) cell on the pyramid, animates
// the sprite offset one step per video frame, and keeps the visited-cube map.
//
// Command handshake: jump_valid/jump_dir form a command that is accepted only
// in the edge where busy is low and jump_dir is a legal code (001..100). While
// busy is high, jump_valid is dropped on the floor (there is no queue), so
// busy acts as the inverted ready of this interface.
module qbert_move_ctrl #(
  parameter int          N_cube     = 28,
  parameter int          N_ROWS     = 7,
  parameter logic [10:0] X_ORIGIN   = 11'd40,
  parameter logic [9:0]  Y_ORIGIN   = 10'd240,
  parameter int          ROW_DX     = 64,
  parameter int          HALF_DY    = 32,
  parameter int          N_STEPS    = 8,
  parameter int          FALL_STEPS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              jump_valid,
  input  logic [2:0]        jump_dir,
  input  logic              clear_map,
  output logic              busy,
  output logic [2:0]        qbert_jump,
  output logic              done_move,
  output logic              fell,
  output logic [20:0]       qbert_xy,
  output logic [N_cube-1:0] top_color_map,
  output logic              level_done,
  output logic [1:0]        dbg_state
);

  localparam int CNT_MAX = (FALL_STEPS > N_STEPS) ? FALL_STEPS : N_STEPS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int RW      = $clog2(N_ROWS);
  localparam int IW      = $clog2(N_cube);

  localparam logic [10:0]   DX_STEP   = 11'(ROW_DX / N_STEPS);
  localparam logic [9:0]    DY_STEP   = 10'(HALF_DY / N_STEPS);
  localparam logic [CW-1:0] MOVE_LAST = CW'(N_STEPS - 1);
  localparam logic [CW-1:0] FALL_LAST = CW'(FALL_STEPS - 1);
  localparam logic [CW-1:0] MOVE_LEN  = CW'(N_STEPS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_LAND = 2'd2,
    S_FALL = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        dir_q;
  logic [RW-1:0]     row_q, col_q;
  logic [RW-1:0]     tgt_r_q, tgt_c_q;
  logic [CW-1:0]     cnt_q;
  logic [10:0]       x_q;
  logic [9:0]        y_q;
  logic              done_q, fell_q;
  logic [N_cube-1:0] map_q;
  logic              level_q;

  int                tr, tc;
  logic              dir_ok, tgt_off, accept;
  logic              dir_up, dir_right;
  logic [10:0]       step_x;
  logic [9:0]        step_y;
  logic              land_set;
  logic [N_cube-1:0] land_mask;

  // Screen position of a cube's top vertex; arithmetic wraps at the field width.
  function automatic logic [10:0] cube_x(input logic [RW-1:0] r);
    return X_ORIGIN + 11'(int'(r) * ROW_DX);
  endfunction

  function automatic logic [9:0] cube_y(input logic [RW-1:0] r, input logic [RW-1:0] c);
    return Y_ORIGIN - 10'(int'(r) * HALF_DY) + 10'(2 * int'(c) * HALF_DY);
  endfunction

  function automatic logic [IW-1:0] cube_idx(input logic [RW-1:0] r, input logic [RW-1:0] c);
    return IW'((int'(r) * (int'(r) + 1)) / 2 + int'(c));
  endfunction

  // Decode the requested direction into a target cell and flag off-pyramid targets.
  always_comb begin
    tr     = int'(row_q);
    tc     = int'(col_q);
    dir_ok = 1'b1;
    case (jump_dir)
      3'b001: tr = tr - 1;
      3'b010: begin tr = tr - 1; tc = tc - 1; end
      3'b011: begin tr = tr + 1; tc = tc + 1; end
      3'b100: tr = tr + 1;
      default: dir_ok = 1'b0;
    endcase
    tgt_off = (tr < 0) || (tr >= N_ROWS) || (tc < 0) || (tc > tr);
    accept  = (state_q == S_IDLE) && jump_valid && dir_ok;
  end

  // One animation step in the latched direction: up moves -x, right moves +y.
  always_comb begin
    dir_up    = (dir_q == 3'b001) || (dir_q == 3'b010);
    dir_right = dir_q[0];
    step_x    = dir_up    ? (x_q - DX_STEP) : (x_q + DX_STEP);
    step_y    = dir_right ? (y_q + DY_STEP) : (y_q - DY_STEP);
    land_set  = (state_q == S_MOVE) && frame_tick && (cnt_q == MOVE_LAST);
    land_mask = {{(N_cube-1){1'b0}}, 1'b1} << cube_idx(tgt_r_q, tgt_c_q);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: the last counted tick of a move enters LAND, the last
  // tick of a fall returns straight to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = tgt_off ? S_FALL : S_MOVE;
      S_MOVE: if (frame_tick && (cnt_q == MOVE_LAST)) state_d = S_LAND;
      S_LAND: state_d = S_IDLE;
      S_FALL: if (frame_tick && (cnt_q == FALL_LAST)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Position, counter and done/fell pulses; landing snaps to the exact cube spot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_q   <= 3'b000;
      row_q   <= '0;
      col_q   <= '0;
      tgt_r_q <= '0;
      tgt_c_q <= '0;
      cnt_q   <= '0;
      x_q     <= X_ORIGIN;
      y_q     <= Y_ORIGIN;
      done_q  <= 1'b0;
      fell_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      fell_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            dir_q   <= jump_dir;
            tgt_r_q <= RW'(tr);
            tgt_c_q <= RW'(tc);
            cnt_q   <= '0;
          end
        end
        S_MOVE: begin
          if (frame_tick) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == MOVE_LAST) begin
              row_q  <= tgt_r_q;
              col_q  <= tgt_c_q;
              x_q    <= cube_x(tgt_r_q);
              y_q    <= cube_y(tgt_r_q, tgt_c_q);
              done_q <= 1'b1;
            end else begin
              x_q <= step_x;
              y_q <= step_y;
            end
          end
        end
        S_FALL: begin
          if (frame_tick) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == FALL_LAST) begin
              row_q  <= '0;
              col_q  <= '0;
              x_q    <= X_ORIGIN;
              y_q    <= Y_ORIGIN;
              done_q <= 1'b1;
              fell_q <= 1'b1;
            end else if (cnt_q < MOVE_LEN) begin
              x_q <= step_x;
              y_q <= step_y;
            end else begin
              x_q <= x_q + DX_STEP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Visited map: clear wins over history but never over a same-cycle landing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      map_q   <= '0;
      level_q <= 1'b0;
    end else begin
      if (clear_map)     map_q <= land_set ? land_mask : '0;
      else if (land_set) map_q <= map_q | land_mask;
      level_q <= &map_q;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign qbert_jump    = busy ? dir_q : 3'b000;
  assign done_move     = done_q;
  assign fell          = fell_q;
  assign qbert_xy      = {x_q, y_q};
  assign top_color_map = map_q;
  assign level_done    = level_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_qbert_move_ctrl.sv
// Bench for qbert_move_ctrl: randomized jumps checked against a cell-level
// model of the pyramid (position formulas, visited set, fall path).
module tb_qbert_move_ctrl;

  localparam int N_ROWS     = 7;
  localparam int N_STEPS    = 8;
  localparam int FALL_STEPS = 16;
  localparam int DX         = 8;
  localparam int DY         = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_tick = 1'b0;
  logic        jump_valid = 1'b0;
  logic [2:0]  jump_dir = 3'b000;
  logic        clear_map = 1'b0;
  logic        busy;
  logic [2:0]  qbert_jump;
  logic        done_move;
  logic        fell;
  logic [20:0] qbert_xy;
  logic [27:0] top_color_map;
  logic        level_done;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  qbert_move_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .jump_valid    (jump_valid),
    .jump_dir      (jump_dir),
    .clear_map     (clear_map),
    .busy          (busy),
    .qbert_jump    (qbert_jump),
    .done_move     (done_move),
    .fell          (fell),
    .qbert_xy      (qbert_xy),
    .top_color_map (top_color_map),
    .level_done    (level_done),
    .dbg_state     (dbg_state)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [20:0] exp_q[$];
  int          m_r, m_c;
  logic [27:0] m_map;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [20:0] pos(input int r, input int c);
    int x, y;
    x = 40 + r * 64;
    y = 240 - r * 32 + 2 * c * 32;
    return {11'(x), 10'(y)};
  endfunction

  function automatic int idx(input int r, input int c);
    return r * (r + 1) / 2 + c;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge: apply inputs, let one posedge pass, return at the next negedge.
  task automatic drive(input bit tick, input bit jv, input logic [2:0] dir, input bit clr);
    frame_tick = tick;
    jump_valid = jv;
    jump_dir   = dir;
    clear_map  = clr;
    @(posedge clk);
    @(negedge clk);
    frame_tick = 1'b0;
    jump_valid = 1'b0;
    jump_dir   = 3'b000;
    clear_map  = 1'b0;
  endtask

  task automatic illegal_cmd(input logic [2:0] dir);
    drive(1'($urandom_range(0, 1)), 1'b1, dir, 1'b0);
    check("illegal_busy", busy, 0);
    check("illegal_xy", qbert_xy, pos(m_r, m_c));
  endtask

  task automatic do_jump(input logic [2:0] dir, input bit clr_on_land);
    int tr, tc, sx, sy, x0, y0, n, gap;
    bit off, old_ld;
    logic [20:0] e;
    tr = m_r;
    tc = m_c;
    case (dir)
      3'd1: tr = tr - 1;
      3'd2: begin tr = tr - 1; tc = tc - 1; end
      3'd3: begin tr = tr + 1; tc = tc + 1; end
      default: tr = tr + 1;
    endcase
    off = (tr < 0) || (tr >= N_ROWS) || (tc < 0) || (tc > tr);
    sx  = (dir == 3'd1 || dir == 3'd2) ? -DX : DX;
    sy  = (dir == 3'd1 || dir == 3'd3) ? DY : -DY;
    x0  = 40 + m_r * 64;
    y0  = 240 - m_r * 32 + m_c * 64;
    n   = off ? FALL_STEPS : N_STEPS;
    for (int k = 1; k <= n; k++) begin
      if (k == n)             e = off ? pos(0, 0) : pos(tr, tc);
      else if (k <= N_STEPS)  e = {11'(x0 + k * sx), 10'(y0 + k * sy)};
      else                    e = {11'(x0 + N_STEPS * sx + (k - N_STEPS) * DX), 10'(y0 + N_STEPS * sy)};
      exp_q.push_back(e);
    end

    check("pre_busy", busy, 0);
    // Accept cycle, sometimes with a frame tick that must not count.
    drive(1'($urandom_range(0, 1)), 1'b1, dir, 1'b0);
    check("accept_busy", busy, 1);
    check("accept_jump", qbert_jump, dir);
    check("accept_xy", qbert_xy, pos(m_r, m_c));

    for (int k = 1; k <= n; k++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        drive(1'b0, 1'($urandom_range(0, 1)), 3'd4, 1'b0);
        check("gap_busy", busy, 1);
        check("gap_done", done_move, 0);
      end
      drive(1'b1, 1'b0, 3'd0, clr_on_land && (k == n));
      check("step_xy", qbert_xy, exp_q.pop_front());
      if (k < n) begin
        check("step_jump", qbert_jump, dir);
        check("step_done", done_move, 0);
      end
    end

    old_ld = &m_map;
    if (off) begin
      m_r = 0;
      m_c = 0;
    end else begin
      if (clr_on_land) m_map = 28'd1 << idx(tr, tc);
      else             m_map = m_map | (28'd1 << idx(tr, tc));
      m_r = tr;
      m_c = tc;
    end
    check("end_done", done_move, 1);
    check("end_fell", fell, 32'(off));
    check("end_map", top_color_map, m_map);
    check("end_level_lag", level_done, 32'(old_ld));
    check("end_busy", busy, off ? 0 : 1);
    check("end_jump", qbert_jump, off ? 0 : 32'(dir));

    drive(1'b0, 1'b0, 3'd0, 1'b0);
    check("post_done", done_move, 0);
    check("post_fell", fell, 0);
    check("post_busy", busy, 0);
    check("post_jump", qbert_jump, 0);
    check("post_level", level_done, 32'(&m_map));
    check("post_xy", qbert_xy, pos(m_r, m_c));
  endtask

  // Start a jump, abort it with reset after three counted ticks.
  task automatic reset_mid_move();
    logic [2:0] d;
    d = (m_r < N_ROWS - 1) ? 3'd3 : ((m_c == 0) ? 3'd1 : 3'd2);
    drive(1'b0, 1'b1, d, 1'b0);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 3'd0, 1'b0);
    check("mid_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("rst_xy", qbert_xy, pos(0, 0));
    check("rst_busy", busy, 0);
    check("rst_jump", qbert_jump, 0);
    check("rst_map", top_color_map, 0);
    check("rst_done", done_move, 0);
    @(negedge clk);
    reset = 1'b1;
    m_r = 0;
    m_c = 0;
    m_map = '0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0, 3'd0, 1'b0);
      check("rst_no_done", done_move, 0);
    end
  endtask

  // ---------------- stimulus ----------------
  int tour[$] = '{4,1,4,4,4,4,4,4,1,3,1,1,1,1,1,3,4,4,4,4,1,3,1,1,1,3,4,4,1,3,1,3};

  initial begin
    logic [2:0] d;
    m_r = 0;
    m_c = 0;
    m_map = '0;
    repeat (3) @(negedge clk);
    check("reset_xy", qbert_xy, {11'd40, 10'd240});
    check("reset_map", top_color_map, 0);
    check("reset_busy", busy, 0);
    check("reset_jump", qbert_jump, 0);
    check("reset_done", done_move, 0);
    check("reset_fell", fell, 0);
    check("reset_level", level_done, 0);
    reset = 1'b1;
    @(negedge clk);

    illegal_cmd(3'd0);
    illegal_cmd(3'd5);
    illegal_cmd(3'd6);
    illegal_cmd(3'd7);

    do_jump(3'd3, 1'b0);   // (0,0) -> (1,1)
    check("first_map", top_color_map, 28'h4);
    do_jump(3'd1, 1'b0);   // (1,1) -> (0,1) is off-pyramid: fall
    do_jump(3'd2, 1'b0);   // (0,0) up-left: fall

    repeat (24) begin
      d = 3'($urandom_range(0, 7));
      if (d >= 3'd1 && d <= 3'd4) do_jump(d, 1'b0);
      else illegal_cmd(d);
    end

    reset_mid_move();

    foreach (tour[i]) do_jump(3'(tour[i]), 1'b0);
    check("tour_level", level_done, 1);

    do_jump(3'd2, 1'b1);   // (6,6) -> (5,5) with clear on landing
    check("clr_land_map", top_color_map, 28'd1 << 20);

    drive(1'b0, 1'b0, 3'd0, 1'b1);
    check("clear_map", top_color_map, 0);
    drive(1'b0, 1'b0, 3'd0, 1'b0);
    check("clear_level", level_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
